inv_sqrt_arbiter: RTL and testbench

//  Round-robin arbiter that time-shares one pipelined inv_sqrt unit (Q8.24) among N_REQ ray-marcher clients
//  (e.g. ray-dir normalise, SDF normal normalise). Accepts valid/ready requests, issues at most one operand
//  per cycle to the unit, tracks requester ID alongside the fixed unit latency, and returns each result
//  to its owner through a 1-entry per-requester response register with valid/ready.

---
 rtl/vector_pkg.sv | 17 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/inv_sqrt_arbiter.sv | 125 ++++++++++++
 tb/tb_inv_sqrt_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vector_pkg.sv
// Shared types and constants for the vector/ray-marcher datapath blocks.
// isq_tag_t rides alongside an operand through a shared unit so its result can be routed back.
package vector_pkg;

   localparam logic [31:0] FP_ONE  = 32'h0100_0000;
   localparam logic [31:0] SAT_MAX = 32'hFFFF_FFFF;

   // Sized for the largest supported client count (8); smaller arbiters leave upper bits zero.
   localparam int ID_W = 3;

   typedef struct packed {
      logic            vld;
      logic [ID_W-1:0] id;
      logic            zero;
   } isq_tag_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: the first asserted request at or after ptr wins.
// Produces a one-hot grant plus its binary index; reusable for any shared unit.
module rr_arbiter #(
   parameter int N  = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_valid
);

   always_comb begin
      logic [IW:0] cand;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = 1'b0;
      cand        = '0;
      // The extra bit in cand lets ptr+off wrap correctly for non-power-of-2 N.
      for (int off = 0; off < N; off++) begin
         cand = {1'b0, ptr} + (IW+1)'(off);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (!grant_valid && req[cand[IW-1:0]]) begin
            grant_valid               = 1'b1;
            grant[cand[IW-1:0]]       = 1'b1;
            grant_idx                 = cand[IW-1:0];
         end
      end
   end

endmodule

// File: rtl/inv_sqrt_arbiter.sv
// Time-shares one pipelined inv_sqrt unit among N_REQ clients with round-robin issue,
// an ID-tag pipe matching the unit latency, and a 1-entry response register per client.
module inv_sqrt_arbiter
   import vector_pkg::*;
#(
   parameter int                WIDTH   = 32,
   parameter int                N_REQ   = 4,
   parameter int                LATENCY = 2,
   parameter logic [WIDTH-1:0]  SAT_MAX = vector_pkg::SAT_MAX
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [N_REQ-1:0]        req_valid,
   input  logic [N_REQ*WIDTH-1:0]  req_x,
   output logic [N_REQ-1:0]        req_ready,
   output logic [N_REQ-1:0]        rsp_valid,
   output logic [N_REQ*WIDTH-1:0]  rsp_data,
   input  logic [N_REQ-1:0]        rsp_ready,
   output logic [WIDTH-1:0]        us_x,
   input  logic [WIDTH-1:0]        us_result,
   output logic                    busy
);

   localparam int IDX_W = $clog2(N_REQ);

   logic [IDX_W-1:0] ptr;
   logic [IDX_W-1:0] grant_idx;
   logic [N_REQ-1:0] grant;
   logic [N_REQ-1:0] eligible;
   logic [N_REQ-1:0] pending;
   logic [N_REQ-1:0] wb_sel;
   logic             grant_valid;
   logic [WIDTH-1:0] sel_x;
   isq_tag_t         issue_tag;
   isq_tag_t         pipe [LATENCY];
   isq_tag_t         tail;

   // A client with a result still unconsumed cannot issue again, so no writeback ever collides.
   assign eligible  = req_valid & ~pending;
   assign req_ready = grant;
   assign busy      = |pending;
   assign tail      = pipe[LATENCY-1];

   rr_arbiter #(.N(N_REQ)) u_rr (
      .req         (eligible),
      .ptr         (ptr),
      .grant       (grant),
      .grant_idx   (grant_idx),
      .grant_valid (grant_valid)
   );

   always_comb begin
      sel_x = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (grant[i]) begin
            sel_x = req_x[i*WIDTH +: WIDTH];
         end
      end
   end

   always_comb begin
      wb_sel = '0;
      for (int i = 0; i < N_REQ; i++) begin
         wb_sel[i] = tail.vld && (tail.id == ID_W'(i));
      end
   end

   // us_x only loads on a grant so the shared unit sees no toggling while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr       <= '0;
         us_x      <= '0;
         issue_tag <= '0;
      end else begin
         issue_tag <= '{vld: grant_valid, id: ID_W'(grant_idx), zero: grant_valid && (sel_x == '0)};
         if (grant_valid) begin
            ptr  <= (grant_idx == IDX_W'(N_REQ-1)) ? '0 : grant_idx + IDX_W'(1);
            us_x <= sel_x;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < LATENCY; k++) begin
            pipe[k] <= '0;
         end
      end else begin
         pipe[0] <= issue_tag;
         for (int k = 1; k < LATENCY; k++) begin
            pipe[k] <= pipe[k-1];
         end
      end
   end

   // Zero operands bypass the unit result, which is meaningless for x == 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending   <= '0;
         rsp_valid <= '0;
         rsp_data  <= '0;
      end else begin
         for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
               pending[i] <= 1'b1;
            end else if (rsp_valid[i] && rsp_ready[i]) begin
               pending[i] <= 1'b0;
            end
            if (wb_sel[i]) begin
               rsp_valid[i]                <= 1'b1;
               rsp_data[i*WIDTH +: WIDTH]  <= tail.zero ? SAT_MAX : us_result;
            end else if (rsp_valid[i] && rsp_ready[i]) begin
               rsp_valid[i] <= 1'b0;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         assert ((wb_sel & rsp_valid) == '0);
      end
   end

endmodule

// File: tb/tb_inv_sqrt_arbiter.sv
// Directed bench for inv_sqrt_arbiter with a behavioural XOR unit and per-client scoreboard queues.
module tb_inv_sqrt_arbiter;

   localparam int          WIDTH   = 32;
   localparam int          N_REQ   = 4;
   localparam int          LATENCY = 2;
   localparam logic [31:0] XOR_KEY = 32'hA5A5_A5A5;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ*WIDTH-1:0] req_x;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ-1:0]       rsp_valid;
   logic [N_REQ*WIDTH-1:0] rsp_data;
   logic [N_REQ-1:0]       rsp_ready;
   logic [WIDTH-1:0]       us_x;
   logic [WIDTH-1:0]       us_result;
   logic                   busy;

   int total  = 0;
   int passed = 0;
   int failed = 0;

   logic [WIDTH-1:0] exp_q [N_REQ][$];
   int               grant_log [$];
   logic [WIDTH-1:0] unit_s [LATENCY];

   always #5 clk = ~clk;

   inv_sqrt_arbiter #(.WIDTH(WIDTH), .N_REQ(N_REQ), .LATENCY(LATENCY)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_x     (req_x),
      .req_ready (req_ready),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_ready (rsp_ready),
      .us_x      (us_x),
      .us_result (us_result),
      .busy      (busy)
   );

   // Stand-in for the shared unit: LATENCY-deep pipe returning x ^ key.
   always @(posedge clk) begin
      unit_s[0] <= us_x ^ XOR_KEY;
      for (int k = 1; k < LATENCY; k++) begin
         unit_s[k] <= unit_s[k-1];
      end
   end
   assign us_result = unit_s[LATENCY-1];

   task automatic checkOutput(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] modelResult(input logic [WIDTH-1:0] x);
      return (x == '0) ? 32'hFFFF_FFFF : (x ^ XOR_KEY);
   endfunction

   function automatic logic [N_REQ-1:0] sbNonEmpty();
      logic [N_REQ-1:0] nz;
      for (int i = 0; i < N_REQ; i++) begin
         nz[i] = (exp_q[i].size() != 0);
      end
      return nz;
   endfunction

   // Scoreboard: push the expected result on each grant, pop and compare on each response handshake.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         checkOutput("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
         checkOutput("ready_subset_valid", 32'(req_ready & ~req_valid), 32'd0);
         for (int i = 0; i < N_REQ; i++) begin
            if (rsp_valid[i] && rsp_ready[i]) begin
               if (exp_q[i].size() == 0) begin
                  checkOutput($sformatf("rsp_unexpected_%0d", i), 32'(exp_q[i].size()), 32'd1);
               end else begin
                  checkOutput($sformatf("rsp_data_%0d", i), rsp_data[i*WIDTH +: WIDTH], exp_q[i].pop_front());
               end
            end
            if (req_valid[i] && req_ready[i]) begin
               checkOutput($sformatf("one_outstanding_%0d", i), 32'(exp_q[i].size()), 32'd0);
               exp_q[i].push_back(modelResult(req_x[i*WIDTH +: WIDTH]));
               grant_log.push_back(i);
            end
         end
      end
   end

   task automatic applyStimulus(input int cycles);
      logic [N_REQ-1:0] g;
      repeat (cycles) begin
         @(negedge clk);
         g = req_valid & req_ready;
         @(posedge clk);
         #1;
         for (int i = 0; i < N_REQ; i++) begin
            if (g[i]) req_x[i*WIDTH +: WIDTH] = $urandom;
         end
      end
   endtask

   task automatic clearScoreboard();
      for (int i = 0; i < N_REQ; i++) exp_q[i].delete();
      grant_log.delete();
   endtask

   task automatic resetDut();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = '0;
      clearScoreboard();
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_req_ready", 32'(req_ready), 32'd0);
      checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("rst_rsp_data_nz", 32'(rsp_data != '0), 32'd0);
      checkOutput("rst_us_x", us_x, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // busy must track exactly "some result owed", which the scoreboard knows independently.
   task automatic drainWait(input string tag);
      int n = 0;
      logic [N_REQ-1:0] nz;
      do begin
         @(posedge clk);
         #1;
         nz = sbNonEmpty();
         checkOutput({tag, "_busy"}, 32'(busy), 32'(|nz));
         n++;
      end while (busy !== 1'b0 && n < 40);
      checkOutput({tag, "_drained"}, 32'(busy), 32'd0);
      checkOutput({tag, "_sb_empty"}, 32'(sbNonEmpty()), 32'd0);
      checkOutput({tag, "_rsp_idle"}, 32'(rsp_valid), 32'd0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog expired observed=running required=finished");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int n;
      int cnt0;
      int cnt1;
      rst_n     = 1'b0;
      req_valid = '0;
      req_x     = '0;
      rsp_ready = '0;
      resetDut();

      // Single request: same-cycle ready, result three edges after acceptance.
      req_x[0 +: WIDTH] = 32'h0100_0000;
      req_valid         = 4'b0001;
      @(negedge clk);
      checkOutput("t1_ready", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1;
      req_valid = '0;
      checkOutput("t1_us_x", us_x, 32'h0100_0000);
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t1_rsp_valid_%0d", k), 32'(rsp_valid[0]), 32'(k == 3));
      end
      checkOutput("t1_rsp_data", rsp_data[0 +: WIDTH], 32'hA4A5_A5A5);
      checkOutput("t1_busy", 32'(busy), 32'd1);
      @(posedge clk);
      #1;
      rsp_ready = '1;
      drainWait("t1");

      // All clients valid: round-robin order starting after requester 0.
      grant_log.delete();
      for (int i = 0; i < N_REQ; i++) req_x[i*WIDTH +: WIDTH] = $urandom;
      req_valid = '1;
      applyStimulus(12);
      req_valid = '0;
      drainWait("t2");
      checkOutput("t2_grant_count_ok", 32'(grant_log.size() >= 8), 32'd1);
      for (int k = 0; k < 8; k++) begin
         checkOutput($sformatf("t2_order_%0d", k), 32'((grant_log.size() > k) ? grant_log[k] : -1), 32'((k + 1) % N_REQ));
      end

      // Backpressure on requester 1 blocks only requester 1.
      resetDut();
      for (int i = 0; i < N_REQ; i++) req_x[i*WIDTH +: WIDTH] = $urandom;
      rsp_ready = 4'b1101;
      req_valid = '1;
      applyStimulus(14);
      cnt0 = 0;
      cnt1 = 0;
      foreach (grant_log[k]) begin
         if (grant_log[k] == 0) cnt0++;
         if (grant_log[k] == 1) cnt1++;
      end
      checkOutput("t3_req1_grants", 32'(cnt1), 32'd1);
      checkOutput("t3_others_progress", 32'(cnt0 >= 2), 32'd1);
      checkOutput("t3_rsp1_held", 32'(rsp_valid[1]), 32'd1);
      req_valid = 4'b0010;
      rsp_ready = '1;
      @(negedge clk);
      checkOutput("t3_release_rsp1", 32'(rsp_valid[1]), 32'd1);
      checkOutput("t3_release_ready", 32'(req_ready), 32'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      checkOutput("t3_rsp1_dropped", 32'(rsp_valid[1]), 32'd0);
      checkOutput("t3_regrant1", 32'(req_ready), 32'b0010);
      @(posedge clk);
      #1;
      req_valid = '0;
      drainWait("t3");

      // Zero operand returns saturation regardless of unit output.
      rsp_ready              = '0;
      req_x[2*WIDTH +: WIDTH] = '0;
      req_valid              = 4'b0100;
      @(negedge clk);
      checkOutput("t4_ready", 32'(req_ready), 32'b0100);
      @(posedge clk);
      #1;
      req_valid = '0;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (rsp_valid[2] !== 1'b1 && n < 10);
      checkOutput("t4_rsp_valid", 32'(rsp_valid[2]), 32'd1);
      checkOutput("t4_latency", 32'(n), 32'd4);
      checkOutput("t4_sat", rsp_data[2*WIDTH +: WIDTH], 32'hFFFF_FFFF);
      @(posedge clk);
      #1;
      rsp_ready = '1;
      drainWait("t4");

      // Reset with three operations in flight discards them and returns ptr to 0.
      resetDut();
      for (int i = 0; i < N_REQ; i++) req_x[i*WIDTH +: WIDTH] = $urandom | 32'h1;
      req_valid = 4'b0111;
      applyStimulus(3);
      rst_n     = 1'b0;
      req_valid = '0;
      clearScoreboard();
      @(negedge clk);
      checkOutput("t5_rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("t5_busy", 32'(busy), 32'd0);
      checkOutput("t5_us_x", us_x, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         checkOutput($sformatf("t5_no_late_wb_%0d", k), 32'(rsp_valid), 32'd0);
      end
      @(posedge clk);
      #1;
      req_valid = 4'b1001;
      @(negedge clk);
      checkOutput("t5_ptr_zero", 32'(req_ready), 32'b0001);
      @(posedge clk);
      #1;
      req_valid = '0;
      rsp_ready = '1;
      drainWait("t5");

      // Two clients only: strict alternation, busy clears only after drain.
      resetDut();
      for (int i = 0; i < N_REQ; i++) req_x[i*WIDTH +: WIDTH] = $urandom;
      rsp_ready = '1;
      req_valid = 4'b1001;
      applyStimulus(16);
      req_valid = '0;
      checkOutput("t6_grant_count_ok", 32'(grant_log.size() >= 6), 32'd1);
      for (int k = 0; k < 6; k++) begin
         checkOutput($sformatf("t6_alt_%0d", k), 32'((grant_log.size() > k) ? grant_log[k] : -1), 32'((k % 2 == 0) ? 0 : 3));
      end
      drainWait("t6");

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
